// File: rtl/fft_pkg.sv
// fft_pkg: shared sizes, complex word packing helpers and sequencer state encoding for the 16-point FFT.
package fft_pkg;
    localparam int FFT_N   = 16;
    localparam int CPLX_W  = 32;
    localparam int HALF_W  = 16;
    localparam int FRAME_W = FFT_N * CPLX_W;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } seq_state_e;

    function automatic logic [CPLX_W-1:0] cplx_pack(input logic [HALF_W-1:0] re, input logic [HALF_W-1:0] im);
        return {re, im};
    endfunction

    function automatic logic [HALF_W-1:0] cplx_re(input logic [CPLX_W-1:0] w);
        return w[CPLX_W-1:HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] cplx_im(input logic [CPLX_W-1:0] w);
        return w[HALF_W-1:0];
    endfunction
endpackage

// File: rtl/fft_in_bank.sv
// fft_in_bank: 16x32 sample bank with indexed write, zero-fill past an early last sample, full flag and clear.
module fft_in_bank
    import fft_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic [CPLX_W-1:0]  data_i,
    input  logic               last_i,
    input  logic               clr_i,
    output logic [FRAME_W-1:0] frame_o,
    output logic               full_o
);
    logic [FFT_N-1:0][CPLX_W-1:0] mem_q, mem_d;
    logic                         full_q, full_d;

    // clear is applied before a completing write so a freed bank can refill in the same cycle
    always_comb begin
        mem_d  = mem_q;
        full_d = full_q && !clr_i;
        if (we_i) begin
            for (int k = 0; k < FFT_N; k++) begin
                if (k == int'(idx_i)) mem_d[k] = data_i;
                else if (last_i && k > int'(idx_i)) mem_d[k] = cplx_pack('0, '0);
            end
            full_d = full_d || last_i || idx_i == IDX_W'(FFT_N - 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q  <= '0;
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            full_q <= full_d;
        end
    end

    assign frame_o = mem_q;
    assign full_o  = full_q;
endmodule

// File: rtl/fft_frame_seq.sv
// fft_frame_seq: gathers serial samples into 16-word frames, drives the FFT core and holds its results.
// FFT_FRAME_SEQ_PINGPONG_EN selects two input banks; otherwise a single bank is used.
module fft_frame_seq
    import fft_pkg::*;
#(
    parameter int CORE_LAT   = 1,
    parameter int FRAME_ID_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CPLX_W-1:0]     in_d,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [FRAME_W-1:0]    core_in,
    input  logic [FRAME_W-1:0]    core_out,
    output logic [FRAME_W-1:0]    out_d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [FRAME_ID_W-1:0] frame_id,
    output logic                  done
);
`ifdef FFT_FRAME_SEQ_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif
    localparam int NB = PP ? 2 : 1;

    logic [1:0]                  full;
    logic [1:0][FRAME_W-1:0]     bank_frame;
    logic                        acc, comp, hs, fin;
    logic [IDX_W-1:0]            wr_idx_q, wr_idx_d;
    logic                        wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic                        pend_q, pend_d;
    logic [1:0]                  tag_q, tag_d;
    seq_state_e                  st_q, st_d;
    logic [2:0]                  cnt_q, cnt_d;
    logic [FRAME_W-1:0]          res_q, res_d;
    logic [FRAME_ID_W-1:0]       fid_q, fid_d, fcnt_q, fcnt_d;

    genvar b;
    for (b = 0; b < 2; b++) begin : g_bank
        if (b < NB) begin : g_on
            fft_in_bank u_bank (
                .clk     (clk),
                .rst     (rst),
                .we_i    (acc && wr_bank_q == 1'(b)),
                .idx_i   (wr_idx_q),
                .data_i  (in_d),
                .last_i  (in_last),
                .clr_i   (hs && rd_bank_q == 1'(b)),
                .frame_o (bank_frame[b]),
                .full_o  (full[b])
            );
        end else begin : g_off
            assign bank_frame[b] = '0;
            assign full[b]       = 1'b0;
        end
    end

    assign in_ready  = !full[wr_bank_q] && !pend_q;
    assign acc       = in_valid && in_ready;
    assign comp      = acc && (in_last || wr_idx_q == IDX_W'(FFT_N - 1));
    assign hs        = st_q == ST_HOLD && out_ready;
    assign fin       = hs && tag_q[rd_bank_q];
    assign core_in   = bank_frame[rd_bank_q];
    assign out_d     = res_q;
    assign out_valid = st_q == ST_HOLD;
    assign frame_id  = fid_q;
    assign done      = fin;

    // the frame tagged by in_last re-arms everything for a fresh stream when it is accepted downstream
    always_comb begin
        wr_idx_d  = comp ? '0 : acc ? wr_idx_q + 1'b1 : wr_idx_q;
        wr_bank_d = fin ? 1'b0 : comp ? (PP & ~wr_bank_q) : wr_bank_q;
        rd_bank_d = fin ? 1'b0 : hs ? (PP & ~rd_bank_q) : rd_bank_q;
        pend_d    = fin ? 1'b0 : pend_q || (acc && in_last);
        tag_d     = tag_q;
        if (hs) tag_d[rd_bank_q] = 1'b0;
        if (comp) tag_d[wr_bank_q] = in_last;
    end

    // a bank completing this cycle starts the settle count at once so out_valid lands CORE_LAT after full
    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        fid_d  = fid_q;
        fcnt_d = fcnt_q;
        case (st_q)
            ST_IDLE: begin
                if (full[rd_bank_q] || (comp && wr_bank_q == rd_bank_q)) begin
                    st_d  = ST_SETTLE;
                    cnt_d = 3'(CORE_LAT - 1);
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    st_d  = ST_HOLD;
                    res_d = core_out;
                    fid_d = fcnt_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    st_d   = ST_IDLE;
                    fcnt_d = fin ? '0 : fcnt_q + 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_idx_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            pend_q    <= 1'b0;
            tag_q     <= '0;
            st_q      <= ST_IDLE;
            cnt_q     <= '0;
            res_q     <= '0;
            fid_q     <= '0;
            fcnt_q    <= '0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            pend_q    <= pend_d;
            tag_q     <= tag_d;
            st_q      <= st_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            fid_q     <= fid_d;
            fcnt_q    <= fcnt_d;
        end
    end
endmodule
